// File: rtl/mem_access_arbiter.sv
// Two-port round-robin arbiter in front of a single byte-addressed memory.
// Sub-word stores are done as read-modify-write through a merge register.
module mem_access_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int BYTE_SIZE  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_0,
  input  logic                    we_0,
  input  logic [1:0]              size_0,
  input  logic [ADDR_WIDTH-1:0]   addr_0,
  input  logic [8*BYTE_SIZE-1:0]  wdata_0,
  input  logic                    req_1,
  input  logic                    we_1,
  input  logic [1:0]              size_1,
  input  logic [ADDR_WIDTH-1:0]   addr_1,
  input  logic [8*BYTE_SIZE-1:0]  wdata_1,
  output logic                    ack_0,
  output logic [8*BYTE_SIZE-1:0]  rdata_0,
  output logic                    ack_1,
  output logic [8*BYTE_SIZE-1:0]  rdata_1,
  output logic                    MemWrite,
  output logic [ADDR_WIDTH-1:0]   ADDR,
  output logic [8*BYTE_SIZE-1:0]  WD,
  input  logic [8*BYTE_SIZE-1:0]  RD,
  output logic                    busy
);

  localparam int DW = 8 * BYTE_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE
  } state_e;

  state_e                state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  last_q, last_d;
  logic                  we_q, we_d;
  logic [1:0]            size_q, size_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic [DW-1:0]         merge_q, merge_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [DW-1:0]         rdata0_q, rdata0_d;
  logic [DW-1:0]         rdata1_q, rdata1_d;
  logic [DW-1:0]         mask;
  logic                  sel;

  always_comb begin
    case (size_q)
      2'b00:   mask = DW'(8'hFF);
      2'b01:   mask = DW'(16'hFFFF);
      default: mask = '1;
    endcase
  end

  // Tie goes to the port not served last; a lone request wins outright.
  assign sel = (req_0 & req_1) ? ~last_q : req_1;

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    we_d     = we_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merge_d  = merge_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    MemWrite = 1'b0;
    WD       = '0;
    unique case (state_q)
      IDLE: begin
        if (req_0 | req_1) begin
          gnt_d   = sel;
          last_d  = sel;
          we_d    = sel ? we_1 : we_0;
          size_d  = sel ? size_1 : size_0;
          addr_d  = sel ? addr_1 : addr_0;
          wdata_d = sel ? wdata_1 : wdata_0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) begin
          if (gnt_q) rdata1_d = RD & mask;
          else       rdata0_d = RD & mask;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = IDLE;
        end else if (size_q[1]) begin
          MemWrite = 1'b1;
          WD       = wdata_q;
          ack0_d   = ~gnt_q;
          ack1_d   = gnt_q;
          state_d  = IDLE;
        end else begin
          merge_d = (RD & ~mask) | (wdata_q & mask);
          state_d = WRITE;
        end
      end
      WRITE: begin
        MemWrite = 1'b1;
        WD       = merge_q;
        ack0_d   = ~gnt_q;
        ack1_d   = gnt_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      we_q     <= we_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign ADDR    = (state_q == IDLE) ? '0 : addr_q;
  assign busy    = (state_q != IDLE);
  assign ack_0   = ack0_q;
  assign ack_1   = ack1_q;
  assign rdata_0 = rdata0_q;
  assign rdata_1 = rdata1_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a 256-byte wrapping memory.
module tb_mem_access_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_0 = 0, we_0 = 0, req_1 = 0, we_1 = 0;
  logic [1:0]    size_0 = 0, size_1 = 0;
  logic [AW-1:0] addr_0 = 0, addr_1 = 0;
  logic [DW-1:0] wdata_0 = 0, wdata_1 = 0;
  logic          ack_0, ack_1, MemWrite, busy;
  logic [DW-1:0] rdata_0, rdata_1, WD, RD;
  logic [AW-1:0] ADDR;
  logic [7:0]    mem [256];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_arbiter #(.ADDR_WIDTH(AW), .BYTE_SIZE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .we_0(we_0), .size_0(size_0),
    .addr_0(addr_0), .wdata_0(wdata_0),
    .req_1(req_1), .we_1(we_1), .size_1(size_1),
    .addr_1(addr_1), .wdata_1(wdata_1),
    .ack_0(ack_0), .rdata_0(rdata_0),
    .ack_1(ack_1), .rdata_1(rdata_1),
    .MemWrite(MemWrite), .ADDR(ADDR), .WD(WD), .RD(RD),
    .busy(busy)
  );

  always_comb begin
    RD = '0;
    for (int b = 0; b < 4; b++)
      RD[8*b +: 8] = mem[8'(ADDR[7:0] + 8'(b))];
  end

  always @(posedge clk)
    if (MemWrite)
      for (int b = 0; b < 4; b++)
        mem[8'(ADDR[7:0] + 8'(b))] <= WD[8*b +: 8];

  function automatic logic [31:0] mword(input logic [7:0] a);
    return {mem[8'(a+3)], mem[8'(a+2)], mem[8'(a+1)], mem[a]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_txn(input bit p, input bit we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output int wr,
                        output logic [31:0] rd);
    bit done = 0;
    lat = 99;
    wr = 0;
    @(posedge clk); #1;
    if (p) begin
      req_1 = 1; we_1 = we; size_1 = sz; addr_1 = a; wdata_1 = wd;
    end else begin
      req_0 = 1; we_0 = we; size_0 = sz; addr_0 = a; wdata_0 = wd;
    end
    for (int i = 1; i <= 8 && !done; i++) begin
      @(posedge clk); #1;
      if (MemWrite) wr++;
      check("no_dual_ack", {63'd0, ack_0 & ack_1}, 64'd0);
      if ((p ? ack_1 : ack_0) === 1'b1) begin
        lat = i;
        done = 1;
        req_0 = 0;
        req_1 = 0;
      end
    end
    req_0 = 0;
    req_1 = 0;
    rd = p ? rdata_1 : rdata_0;
  endtask

  int lat, wr, nack, first, last;
  logic [31:0] rd;
  logic [3:0] ord;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    #12;
    check("rst_busy", {63'd0, busy}, 0);
    check("rst_memwrite", {63'd0, MemWrite}, 0);
    check("rst_addr", ADDR, 0);
    check("rst_wd", WD, 0);
    check("rst_acks", {62'd0, ack_1, ack_0}, 0);
    check("rst_rdata", {rdata_1, rdata_0}, 0);
    rst_n = 1;

    do_txn(0, 1, 2'b10, 32'h10, 32'hAABBCCDD, lat, wr, rd);
    check("wst_lat", lat, 2);
    check("wst_writes", wr, 1);
    check("wst_mem", mword(8'h10), 32'hAABBCCDD);

    do_txn(0, 0, 2'b10, 32'h10, 32'h0, lat, wr, rd);
    check("wld_lat", lat, 2);
    check("wld_writes", wr, 0);
    check("wld_rdata", rd, 32'hAABBCCDD);

    do_txn(1, 1, 2'b00, 32'h10, 32'h00000011, lat, wr, rd);
    check("bst_lat", lat, 3);
    check("bst_writes", wr, 1);
    check("bst_mem", mword(8'h10), 32'hAABBCC11);
    check("bst_rdata1_kept", rdata_1, 0);
    check("bst_rdata0_kept", rdata_0, 32'hAABBCCDD);

    do_txn(0, 0, 2'b00, 32'h12, 32'h0, lat, wr, rd);
    check("bld_lat", lat, 2);
    check("bld_rdata", rd, 32'h000000BB);

    do_txn(1, 0, 2'b01, 32'h10, 32'h0, lat, wr, rd);
    check("hld_lat", lat, 2);
    check("hld_rdata", rd, 32'h0000CC11);
    check("hld_rdata0_kept", rdata_0, 32'h000000BB);

    // Both ports contend; last grant was port 1.
    @(posedge clk); #1;
    we_0 = 0; size_0 = 2'b10; addr_0 = 32'h10;
    we_1 = 0; size_1 = 2'b00; addr_1 = 32'h12;
    req_0 = 1; req_1 = 1;
    nack = 0; ord = 0; first = 0; last = 0;
    for (int i = 1; i <= 20 && nack < 4; i++) begin
      @(posedge clk); #1;
      check("rr_no_dual_ack", {63'd0, ack_0 & ack_1}, 0);
      if (ack_0 | ack_1) begin
        ord[nack] = ack_1;
        if (nack == 0) first = i;
        last = i;
        nack++;
        if (nack == 4) begin
          req_0 = 0;
          req_1 = 0;
        end
      end
    end
    req_0 = 0; req_1 = 0;
    check("rr_acks", nack, 4);
    check("rr_order", ord, 4'b1010);
    check("rr_spacing", last - first, 6);
    check("rr_rdata0", rdata_0, 32'hAABBCC11);
    check("rr_rdata1", rdata_1, 32'h000000BB);

    // Reset pulse while the half store sits in WRITE.
    @(posedge clk); #1;
    req_0 = 1; we_0 = 1; size_0 = 2'b01;
    addr_0 = 32'h10; wdata_0 = 32'h00005555;
    @(posedge clk); #1;
    check("rw_access_busy", {63'd0, busy}, 1);
    @(posedge clk); #1;
    check("rw_write_memwrite", {63'd0, MemWrite}, 1);
    req_0 = 0;
    rst_n = 0;
    #1;
    check("rw_rst_memwrite", {63'd0, MemWrite}, 0);
    check("rw_rst_busy", {63'd0, busy}, 0);
    check("rw_rst_addr", ADDR, 0);
    check("rw_rst_rdata0", rdata_0, 0);
    #2 rst_n = 1;
    nack = 0; wr = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (ack_0 | ack_1) nack++;
      if (MemWrite | busy) wr++;
    end
    check("rw_no_ack", nack, 0);
    check("rw_idle", wr, 0);
    check("rw_mem", mword(8'h10), 32'hAABBCC11);

    // Requester drops req and changes addr while in flight.
    @(posedge clk); #1;
    req_0 = 1; we_0 = 1; size_0 = 2'b10;
    addr_0 = 32'h20; wdata_0 = 32'h12345678;
    nack = 0; lat = 99;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        req_0 = 0;
        addr_0 = 32'h30;
      end
      if (ack_0) begin
        nack++;
        lat = i;
      end
    end
    check("drop_acks", nack, 1);
    check("drop_lat", lat, 2);
    check("drop_mem_latched", mword(8'h20), 32'h12345678);
    check("drop_mem_other", mword(8'h30), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
